// File: rtl/vpu_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vpu_issue : vector register file plus 4-state issue FSM feeding an external vALU
// Revision  : 1.0
// ---------------------------------------------------------------------------
module vpu_issue #(
  parameter int VLEN = 128,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  input  logic [1:0]      cfg_vsew,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [2:0]      instr_op,
  input  logic [4:0]      instr_vd,
  input  logic [4:0]      instr_vs1,
  input  logic [4:0]      instr_vs2,
  input  logic [VLEN-1:0] instr_scalar,
  output logic [VLEN-1:0] reg_in1,
  output logic [VLEN-1:0] reg_in2,
  output logic [VLEN-1:0] reg_scalar_in,
  output logic [2:0]      valu_op,
  output logic [7:0]      SEW,
  input  logic [VLEN-1:0] reg_dest,
  input  logic            ext_we,
  input  logic [4:0]      ext_waddr,
  input  logic [VLEN-1:0] ext_wdata,
  input  logic [4:0]      ext_raddr,
  output logic [VLEN-1:0] ext_rdata,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      vsew_q, vsew_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      vd_q, vd_d;
  logic [4:0]      vs1_q, vs1_d;
  logic [4:0]      vs2_q, vs2_d;
  logic [VLEN-1:0] scalar_q, scalar_d;
  logic [VLEN-1:0] reg_in1_q, reg_in1_d;
  logic [VLEN-1:0] reg_in2_q, reg_in2_d;
  logic [VLEN-1:0] reg_scalar_q, reg_scalar_d;
  logic [2:0]      valu_op_q, valu_op_d;
  logic [7:0]      sew_q, sew_d;
  logic [VLEN-1:0] result_q, result_d;
  logic [VLEN-1:0] vrf_q [NREG];
  logic [VLEN-1:0] vrf_d [NREG];

  always_comb begin
    state_d      = state_q;
    vsew_d       = vsew_q;
    op_d         = op_q;
    vd_d         = vd_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    scalar_d     = scalar_q;
    reg_in1_d    = reg_in1_q;
    reg_in2_d    = reg_in2_q;
    reg_scalar_d = reg_scalar_q;
    valu_op_d    = valu_op_q;
    sew_d        = sew_q;
    result_d     = result_q;
    vrf_d        = vrf_q;

    // Host write first so a same-address writeback below overrides it.
    if (ext_we) vrf_d[ext_waddr] = ext_wdata;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) vsew_d = cfg_vsew;
        if (instr_valid) begin
          op_d     = instr_op;
          vd_d     = instr_vd;
          vs1_d    = instr_vs1;
          vs2_d    = instr_vs2;
          scalar_d = instr_scalar;
          state_d  = READ;
        end
      end
      READ: begin
        reg_in1_d    = vrf_q[vs2_q];
        reg_in2_d    = vrf_q[vs1_q];
        reg_scalar_d = scalar_q;
        valu_op_d    = op_q;
        sew_d        = 8'd8 << vsew_q;
        state_d      = EXEC;
      end
      EXEC: begin
        result_d = reg_dest;
        state_d  = WB;
      end
      WB: begin
        vrf_d[vd_q] = result_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vsew_q       <= 2'd0;
      op_q         <= 3'd0;
      vd_q         <= 5'd0;
      vs1_q        <= 5'd0;
      vs2_q        <= 5'd0;
      scalar_q     <= '0;
      reg_in1_q    <= '0;
      reg_in2_q    <= '0;
      reg_scalar_q <= '0;
      valu_op_q    <= 3'd0;
      sew_q        <= 8'd8;
      result_q     <= '0;
      vrf_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      vsew_q       <= vsew_d;
      op_q         <= op_d;
      vd_q         <= vd_d;
      vs1_q        <= vs1_d;
      vs2_q        <= vs2_d;
      scalar_q     <= scalar_d;
      reg_in1_q    <= reg_in1_d;
      reg_in2_q    <= reg_in2_d;
      reg_scalar_q <= reg_scalar_d;
      valu_op_q    <= valu_op_d;
      sew_q        <= sew_d;
      result_q     <= result_d;
      vrf_q        <= vrf_d;
    end
  end

  assign instr_ready   = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == WB) && !rst;
  assign reg_in1       = reg_in1_q;
  assign reg_in2       = reg_in2_q;
  assign reg_scalar_in = reg_scalar_q;
  assign valu_op       = valu_op_q;
  assign SEW           = sew_q;
  assign ext_rdata     = vrf_q[ext_raddr];

endmodule
`default_nettype wire

// File: tb/tb_vpu_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vpu_issue : directed bench for vpu_issue with an element-wise vALU model
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_vpu_issue;

  localparam int VLEN = 128;
  localparam logic [VLEN-1:0] V1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [VLEN-1:0] V2  = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
  localparam logic [VLEN-1:0] V1B = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [VLEN-1:0] ALL_FF = {16{8'hFF}};
  localparam logic [VLEN-1:0] ALL_FE = {16{8'hFE}};
  localparam logic [VLEN-1:0] SUB_V2_V1 = 128'hFFFDFBF9F7F5F3F1EFEDEBE9E7E5E3E1;
  localparam logic [VLEN-1:0] SUBVX_RES = 128'h77777778_00000000_77777778_00000000;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic [1:0]      cfg_vsew;
  logic            instr_valid;
  logic            instr_ready;
  logic [2:0]      instr_op;
  logic [4:0]      instr_vd, instr_vs1, instr_vs2;
  logic [VLEN-1:0] instr_scalar;
  logic [VLEN-1:0] reg_in1, reg_in2, reg_scalar_in;
  logic [2:0]      valu_op;
  logic [7:0]      SEW;
  logic [VLEN-1:0] reg_dest;
  logic            ext_we;
  logic [4:0]      ext_waddr, ext_raddr;
  logic [VLEN-1:0] ext_wdata, ext_rdata;
  logic            busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  vpu_issue #(.VLEN(VLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_vsew(cfg_vsew),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_vd(instr_vd), .instr_vs1(instr_vs1),
    .instr_vs2(instr_vs2), .instr_scalar(instr_scalar),
    .reg_in1(reg_in1), .reg_in2(reg_in2), .reg_scalar_in(reg_scalar_in),
    .valu_op(valu_op), .SEW(SEW), .reg_dest(reg_dest),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .ext_raddr(ext_raddr), .ext_rdata(ext_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Element-wise vALU: vs2 op vs1 (or vs2 op scalar for .vx forms).
  function automatic logic [VLEN-1:0] valu_model(input logic [2:0] op,
      input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
      input logic [VLEN-1:0] s, input logic [7:0] sew);
    logic [VLEN-1:0] r;
    logic [63:0] m, ea, eb, er;
    int step;
    r    = '0;
    step = (sew < 8'd8) ? 1 : int'(sew) / 8;
    m    = (sew >= 8'd64) ? '1 : ((64'd1 << sew) - 64'd1);
    for (int i = 0; i < 16; i += step) begin
      ea = 64'(a >> (i * 8)) & m;
      eb = (op == 3'd1 || op == 3'd3) ? (s[63:0] & m) : (64'(b >> (i * 8)) & m);
      case (op)
        3'd0, 3'd1: er = ea + eb;
        3'd2, 3'd3: er = ea - eb;
        3'd4:       er = ea * eb;
        default:    er = ea;
      endcase
      r |= VLEN'(er & m) << (i * 8);
    end
    return r;
  endfunction

  always_comb reg_dest = valu_model(valu_op, reg_in1, reg_in2, reg_scalar_in, SEW);

  task automatic check(input string tag, input logic [VLEN-1:0] got,
                       input logic [VLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] addr,
                           input logic [VLEN-1:0] exp);
    ext_raddr = addr;
    #1;
    check(tag, ext_rdata, exp);
  endtask

  // All tasks start and end aligned to a falling edge.
  task automatic ext_write(input logic [4:0] addr, input logic [VLEN-1:0] data);
    ext_we = 1'b1; ext_waddr = addr; ext_wdata = data;
    @(negedge clk);
    ext_we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] vd,
                       input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [VLEN-1:0] sc);
    int t;
    instr_valid = 1'b1; instr_op = op; instr_vd = vd;
    instr_vs1 = vs1; instr_vs2 = vs2; instr_scalar = sc;
    t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("issue_timeout", VLEN'(t), 0);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Called in the READ cycle; returns in the done cycle with cycles since accept.
  task automatic wait_done(output int l);
    l = 1;
    while (!done && l < 12) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_vsew = 2'd0; instr_valid = 1'b0;
    instr_op = 3'd0; instr_vd = 5'd0; instr_vs1 = 5'd0; instr_vs2 = 5'd0;
    instr_scalar = '0; ext_we = 1'b0; ext_waddr = 5'd0; ext_wdata = '0;
    ext_raddr = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", VLEN'(instr_ready), 1);
    check("rst_sew", VLEN'(SEW), 8);
    check("rst_busy", VLEN'(busy), 0);
    check("rst_done", VLEN'(done), 0);
    check("rst_op", VLEN'(valu_op), 0);
    check("rst_in1", reg_in1, 0);
    for (int a = 0; a < 32; a++) check_reg($sformatf("rst_v%0d", a), 5'(a), 0);
    @(negedge clk);

    // vadd.vv v3 = v2 + v1 at SEW 8
    ext_write(5'd1, V1);
    ext_write(5'd2, V2);
    issue(3'd0, 5'd3, 5'd1, 5'd2, '0);
    check("busy_read", VLEN'(busy), 1);
    wait_done(lat);
    check("vadd_latency", VLEN'(lat), 3);
    @(negedge clk);
    check("done_one_cycle", VLEN'(done), 0);
    check_reg("vadd_v3", 5'd3, ALL_FF);

    // cfg and vsub.vx in the same IDLE cycle
    ext_write(5'd1, V1B);
    cfg_valid = 1'b1; cfg_vsew = 2'd2;
    issue(3'd3, 5'd7, 5'd2, 5'd1, 128'h89ABCDEF);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("vx_sew", VLEN'(SEW), 32);
    check("vx_op", VLEN'(valu_op), 3);
    check("vx_scalar", reg_scalar_in, 128'h89ABCDEF);
    check("vx_in1_vs2", reg_in1, V1B);
    check("vx_in2_vs1", reg_in2, V2);
    wait_done(lat);
    @(negedge clk);
    check_reg("vsubvx_v7", 5'd7, SUBVX_RES);
    check("hold_scalar", reg_scalar_in, 128'h89ABCDEF);
    check("hold_op", VLEN'(valu_op), 3);

    // back to SEW 8, then back-to-back dependent adds with valid held
    cfg_valid = 1'b1; cfg_vsew = 2'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    ext_write(5'd1, V1);
    instr_valid = 1'b1; instr_op = 3'd0; instr_vd = 5'd4;
    instr_vs1 = 5'd1; instr_vs2 = 5'd2; instr_scalar = '0;
    @(negedge clk);
    instr_vd = 5'd5; instr_vs1 = 5'd4; instr_vs2 = 5'd4;
    cfg_valid = 1'b1; cfg_vsew = 2'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    lat = 2;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat1", VLEN'(lat), 3);
    check("b2b_ready_in_wb", VLEN'(instr_ready), 0);
    @(negedge clk);
    check("b2b_ready_idle", VLEN'(instr_ready), 1);
    @(negedge clk);
    check("b2b_second_accepted", VLEN'(busy), 1);
    instr_valid = 1'b0;
    wait_done(lat);
    check("b2b_lat2", VLEN'(lat), 3);
    check("cfg_ignored_busy", VLEN'(SEW), 8);
    @(negedge clk);
    check_reg("b2b_v4", 5'd4, ALL_FF);
    check_reg("b2b_v5", 5'd5, ALL_FE);

    // ext write collides with WB at the same address: WB wins
    issue(3'd2, 5'd4, 5'd1, 5'd2, '0);
    @(negedge clk);
    @(negedge clk);
    check("wb_done", VLEN'(done), 1);
    ext_we = 1'b1; ext_waddr = 5'd4; ext_wdata = 128'hDEAD;
    @(negedge clk);
    ext_we = 1'b0;
    check_reg("collide_v4", 5'd4, SUB_V2_V1);

    // ext write to a different address during WB: both land
    issue(3'd0, 5'd4, 5'd1, 5'd2, '0);
    @(negedge clk);
    @(negedge clk);
    ext_we = 1'b1; ext_waddr = 5'd6; ext_wdata = 128'hD6;
    @(negedge clk);
    ext_we = 1'b0;
    check_reg("parallel_v4", 5'd4, ALL_FF);
    check_reg("parallel_v6", 5'd6, 128'hD6);

    // reset during EXEC aborts the instruction
    issue(3'd0, 5'd8, 5'd1, 5'd2, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done_rst", VLEN'(done), 0);
    check("abort_busy", VLEN'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_done", VLEN'(done), 0);
    check("abort_ready", VLEN'(instr_ready), 1);
    check("abort_sew", VLEN'(SEW), 8);
    @(negedge clk);
    check("abort_done_late", VLEN'(done), 0);
    for (int a = 0; a < 32; a++) check_reg($sformatf("abort_v%0d", a), 5'(a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vpu_issue.md
VPU_ISSUE -- requirements
Module: vpu_issue

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits (fixed datapath width of vALU).
REQ-002 SHALL have parameter NREG, default 32, number of vector registers (addresses 5 bits).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  request to load SEW configuration.
REQ-006 SHALL have port cfg_vsew  input  2  SEW encoding: 0=8, 1=16, 2=32, 3=64 bits.
REQ-007 SHALL have port instr_valid  input  1  instruction offered.
REQ-008 SHALL have port instr_ready  output  1  instruction accepted when instr_valid && instr_ready.
REQ-009 SHALL have port instr_op  input  3  vALU opcode (0 vadd.vv, 1 vadd.vx, 2 vsub.vv, 3 vsub.vx, 4 vmul.vv, 5-7 passed through unchanged).
REQ-010 SHALL have ports instr_vd, instr_vs1, instr_vs2  input  5 each  destination and source register indices.
REQ-011 SHALL have port instr_scalar  input  VLEN  scalar operand (x-register value, zero-extended).
REQ-012 SHALL have ports reg_in1, reg_in2, reg_scalar_in  output  VLEN each  registered operands to vALU.
REQ-013 SHALL have ports valu_op  output  3  and SEW  output  8  registered vALU controls (SEW in bits).
REQ-014 SHALL have port reg_dest  input  VLEN  combinational result from vALU.
REQ-015 SHALL have ports ext_we input 1, ext_waddr input 5, ext_wdata input VLEN  host register-file write port.
REQ-016 SHALL have ports ext_raddr input 5, ext_rdata output VLEN  host asynchronous read port.
REQ-017 SHALL have ports busy output 1 (state != IDLE) and done output 1 (one-cycle writeback pulse).

Function
REQ-018 SHALL contain NREG x VLEN register file vrf; reads combinational, writes on clock edge.
REQ-019 SHALL implement FSM IDLE -> READ -> EXEC -> WB -> IDLE; instr_ready = (state == IDLE) && !rst.
REQ-020 IDLE: on handshake SHALL latch op, vd, vs1, vs2, scalar into instruction registers and go to READ.
REQ-021 READ: SHALL load reg_in1 = vrf[vs2], reg_in2 = vrf[vs1], reg_scalar_in = scalar, valu_op = op, SEW = current SEW; go to EXEC.
REQ-022 EXEC: SHALL capture reg_dest into result register; go to WB.
REQ-023 WB: SHALL write result to vrf[vd], pulse done for exactly this cycle, go to IDLE.
REQ-024 Latency: done SHALL assert in the 3rd cycle after the accept edge; max throughput one instruction per 4 cycles.
REQ-025 Operand read SHALL see writes completed in prior cycles, including previous instruction's WB (vd == vs1/vs2 back-to-back is correct).
REQ-026 cfg_valid SHALL update SEW only in IDLE; ignored otherwise; cfg and instr in the same IDLE cycle: instruction SHALL use the new SEW.
REQ-027 ext_we SHALL write at any state; same-cycle collision with WB to same address: WB data SHALL win; different addresses: both written.
REQ-028 Operand outputs SHALL hold their values outside READ (stable for vALU during EXEC/WB/IDLE).
REQ-029 vx ops (1, 3): vs1 SHALL still be read but vALU uses reg_scalar_in; no special casing in this block.

Reset
REQ-030 rst SHALL force state IDLE, SEW=8, valu_op=0, reg_in1/reg_in2/reg_scalar_in=0, result=0, done=0, busy=0, all vrf entries 0.
REQ-031 rst asserted mid-instruction SHALL abort it with no vrf write and no done pulse; rst SHALL override ext_we.

Verification
REQ-032 Reset then ext_rdata for all 32 addresses -> 0; SEW output = 8; instr_ready=1.
REQ-033 ext write v1=0x00..0F bytes incrementing, v2=0xFF..F0 decrementing; vadd.vv vd=3, SEW=8 -> done 3 cycles after accept, v3 = 0xFF in every byte.
REQ-034 cfg_vsew=2 with vsub.vx same cycle, v1=0x0123456789ABCDEF0123456789ABCDEF, scalar 0x89ABCDEF -> SEW output 32, valu_op 3, reg_scalar_in 0x89ABCDEF.
REQ-035 Back-to-back: vadd v4=v1+v2 then vadd v5=v4+v4 with instr_valid held high -> second accepted the cycle after first done; v5 uses updated v4.
REQ-036 ext_we to v4 in the WB cycle of an instruction writing v4 -> v4 holds ALU result; ext_we to v6 same cycle -> v6 updated.
REQ-037 rst pulsed during EXEC -> no done, vd unchanged (0), state IDLE next cycle, instr_ready=1.
